keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD style: active-low rows with pull-ups, column drive outputs) and turns physical presses into a clean hex key code plus a held-level indicator and a one-cycle press pulse. It sits directly upstream of the digital-lock FSM and the SSD display path. Its `keypad_value`/`keypress` pair is the lock's `btn`/`is_a_key_pressed` input. It runs on the 50 MHz domain.

## Interface
- `clk_freq`, default 50_000_000: clock frequency in Hz.
- `scan_rate_hz`, default 1000: column dwell rate. `dwell_cycles = clk_freq/scan_rate_hz`, which must be ≥ 4.
- `stable_scans`, default 4: number of consecutive identical full scans needed to accept a press or a release. Range 1..15.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `row`  in  4: keypad rows, active-low, asynchronous to `clk`.
- `col`  out  4: column drive. Exactly one bit is low and the rest are high.
- `keypad_value`  out  4: hex code of the last accepted key.
- `keypress`  out  1: high while an accepted key is held.
- `key_pulse`  out  1: one-cycle strobe on acceptance of a new press.
- `multi_key`  out  1: high for one cycle after any scan that saw ≥2 keys.

## Operation
- `row` passes through a 2-flop synchronizer. A key reads as pressed when its synchronized row bit is 0.
- Column scan order is col0→col1→col2→col3→col0. Each column is driven low for `dwell_cycles` cycles.
- Rows are sampled on the last dwell cycle of a column (dwell counter = `dwell_cycles-1`). `col` advances on the next cycle.
- After the col3 sample, the scan result is classified as exactly one of: NONE, SINGLE(code), or MULTI.
- Key map, as code[row][col]:
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = 0,F,E,D
- The debounce FSM is evaluated once per scan-complete cycle:
  - IDLE: on SINGLE(k), set cand=k, cnt=1, go to CAND. On NONE or MULTI, stay in IDLE.
  - CAND:
    - SINGLE(cand): cnt++. When cnt reaches `stable_scans`, load `keypad_value`=cand, pulse `key_pulse`, go to PRESSED.
    - SINGLE(other): set cand=other, cnt=1.
    - NONE or MULTI: go to IDLE, cnt=0.
  - PRESSED: `keypress`=1.
    - NONE: rel++. When rel reaches `stable_scans`, go to IDLE and set `keypress`=0.
    - SINGLE(keypad_value): rel=0.
    - SINGLE(other) or MULTI: rel=0 and stay in PRESSED. There is no new pulse until a release is accepted.
- `stable_scans`=1 accepts on the first SINGLE scan. Acceptance applies from IDLE as well as CAND.
- `keypad_value` holds its value after release and changes only on acceptance.
- Counters saturate at `stable_scans` and never wrap.

## Timing
- Reset values:
  - `col`=4'b1110
  - `keypad_value`=0, `keypress`=0, `key_pulse`=0, `multi_key`=0
  - FSM=IDLE, all counters 0, synchronizer flops=1
- One scan takes `4*dwell_cycles` cycles.
- `key_pulse`, the `keypad_value` update and the rise of `keypress` all occur on the same cycle, one cycle after the scan-complete sample.
- Press latency from a stable key to `key_pulse`: at most `(stable_scans+1)*4*dwell_cycles + 3` cycles.
- Release latency to the fall of `keypress` follows the same bound.
- `key_pulse` is never high on two consecutive cycles.
- If `rst` is asserted mid-operation, all state clears immediately, `col` returns to 1110, and any held key must be re-accepted from IDLE.

## Structure
- `keypad_pkg` holds the FSM state enum {IDLE, CAND, PRESSED}, the scan-result enum {NONE, SINGLE, MULTI}, and the 4x4 key-map constant array.
- Sub-module `keypad_col_scanner` owns the dwell counter, column drive, row synchronizer and per-scan capture. It outputs `scan_done`, `scan_class` and `scan_code`.
- The debounce FSM and outputs stay in `keypad_scanner`.

## Test plan
Bench parameters: `clk_freq`=4000, `scan_rate_hz`=1000, giving dwell=4 and scan=16 cycles. `stable_scans`=4. The keypad model drives row r low while `col[c]`=0 for each pressed key (r,c).
- Reset: hold `rst`=0 → `col`=1110 and all outputs are 0. Release reset → `col` steps 1101, 1011, 0111, 1110 every 4 cycles.
- Press '5' (r1,c1) and hold → exactly one `key_pulse`, with `keypad_value`=4'h5 and `keypress`=1, within 83 cycles.
- Bounce on '9': present for 2 scans, absent 1, then present → no pulse until 4 consecutive scans. Then a single pulse with value 9.
- Hold '1' and 'D' together → a `multi_key` strobe on every scan. No `key_pulse` and `keypress`=0 throughout.
- Accept 'A', then release → `keypress` falls after 4 empty scans and `keypad_value` stays 4'hA. Re-press 'A' → a new pulse.
- With '7' accepted, pulse `rst` low for 3 cycles while the key is still held → outputs clear asynchronously. After reset releases, a fresh pulse with value 7 arrives within 83 cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } deb_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_class_e;

  // Indexed as KEY_MAP[row][col].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

endpackage

// File: rtl/keypad_col_scanner.sv
// Column drive, row synchronizer and per-scan capture; classifies each full
// scan as NONE, SINGLE(code) or MULTI on the col3 sample cycle.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int dwell_cycles = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        scan_done,
  output scan_class_e scan_class,
  output logic [3:0]  scan_code
);

  localparam int DCW = (dwell_cycles > 1) ? $clog2(dwell_cycles) : 1;
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(dwell_cycles - 1);

  logic [3:0]     row_meta;
  logic [3:0]     row_sync;
  logic [DCW-1:0] dwell_cnt;
  logic [1:0]     col_idx;
  logic [3:0]     hits [3];
  logic           sample;

  assign sample    = (dwell_cnt == DWELL_LAST);
  assign scan_done = sample && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      hits[0]   <= 4'h0;
      hits[1]   <= 4'h0;
      hits[2]   <= 4'h0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (sample) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        if (col_idx != 2'd3) hits[col_idx] <= ~row_sync;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // col3 is classified straight from the live synchronized rows so the
  // result is ready on the same cycle as its sample.
  logic [3:0] cells [4];
  logic [4:0] n_keys;

  always_comb begin
    cells[0]   = hits[0];
    cells[1]   = hits[1];
    cells[2]   = hits[2];
    cells[3]   = ~row_sync;
    n_keys     = 5'd0;
    scan_code  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (cells[c][r]) begin
          n_keys    = n_keys + 5'd1;
          scan_code = KEY_MAP[r][c];
        end
      end
    end
    if (n_keys == 5'd0)      scan_class = NONE;
    else if (n_keys == 5'd1) scan_class = SINGLE;
    else                     scan_class = MULTI;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: scan-level debounce turning matrix presses into a hex
// code, a held level, a one-cycle press pulse and a multi-key strobe.
//
// state   | meaning
// IDLE    | no key accepted, waiting for a single-key scan
// CAND    | same single key seen on cnt consecutive scans
// PRESSED | key accepted and held; rel counts consecutive empty scans
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int clk_freq     = 50_000_000,
  parameter int scan_rate_hz = 1000,
  parameter int stable_scans = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keypad_value,
  output logic       keypress,
  output logic       key_pulse,
  output logic       multi_key
);

  localparam int         DWELL_CYCLES = clk_freq / scan_rate_hz;
  localparam logic [3:0] SS           = 4'(stable_scans);
  localparam logic [3:0] SS_LAST      = SS - 4'd1;

  logic        scan_done;
  scan_class_e scan_class;
  logic [3:0]  scan_code;

  deb_state_e state;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic [3:0] rel;

  keypad_col_scanner #(
    .dwell_cycles(DWELL_CYCLES)
  ) u_col_scanner (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .scan_done (scan_done),
    .scan_class(scan_class),
    .scan_code (scan_code)
  );

  assign keypress = (state == PRESSED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cand         <= 4'h0;
      cnt          <= 4'd0;
      rel          <= 4'd0;
      keypad_value <= 4'h0;
      key_pulse    <= 1'b0;
      multi_key    <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      multi_key <= scan_done && (scan_class == MULTI);
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (scan_class == SINGLE) begin
              cand <= scan_code;
              if (SS_LAST == 4'd0) begin
                keypad_value <= scan_code;
                key_pulse    <= 1'b1;
                cnt          <= 4'd0;
                rel          <= 4'd0;
                state        <= PRESSED;
              end else begin
                cnt   <= 4'd1;
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (scan_class == SINGLE && scan_code == cand) begin
              if (cnt >= SS_LAST) begin
                keypad_value <= cand;
                key_pulse    <= 1'b1;
                cnt          <= 4'd0;
                rel          <= 4'd0;
                state        <= PRESSED;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else if (scan_class == SINGLE) begin
              cand <= scan_code;
              cnt  <= 4'd1;
            end else begin
              cnt   <= 4'd0;
              state <= IDLE;
            end
          end
          PRESSED: begin
            // Any non-empty scan restarts the release count; a different key
            // cannot be accepted until this one is released.
            if (scan_class == NONE) begin
              if (rel >= SS_LAST) begin
                rel   <= 4'd0;
                state <= IDLE;
              end else begin
                rel <= rel + 4'd1;
              end
            end else begin
              rel <= 4'd0;
            end
          end
          default: begin
            cnt   <= 4'd0;
            rel   <= 4'd0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives the rows, press
// events push expected codes, and a monitor checks every key_pulse.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypad_value;
  logic       keypress;
  logic       key_pulse;
  logic       multi_key;

  logic [3:0][3:0] keys;   // keys[r][c] = 1 while key (r,c) is held
  logic [3:0] exp_q [$];
  logic       prev_pulse = 1'b0;
  int         errors = 0;
  int         checks = 0;

  logic [3:0] tb_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

  always #5 clk = ~clk;

  keypad_scanner #(
    .clk_freq    (4000),
    .scan_rate_hz(1000),
    .stable_scans(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .keypad_value(keypad_value),
    .keypress    (keypress),
    .key_pulse   (key_pulse),
    .multi_key   (multi_key)
  );

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expected press.
  always @(negedge clk) begin
    if (key_pulse) begin
      check("pulse_expected", exp_q.size() != 0, 1);
      check("pulse_not_back_to_back", prev_pulse, 0);
      if (exp_q.size() != 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("pulse_value", keypad_value, e);
        check("pulse_keypress", keypress, 1);
      end
    end
    prev_pulse <= key_pulse;
  end

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_release(input string name, input int budget, output int cycles);
    cycles = 0;
    while (keypress && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check(name, keypress, 0);
  endtask

  task automatic align_scan();
    logic [3:0] prev;
    logic found;
    prev  = col;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = col;
    end
    check("scan_align", found, 1);
  endtask

  task automatic press(input int k);
    keys[k / 4][k % 4] = 1'b1;
  endtask

  initial begin
    int cyc;
    int mcount;
    int kp_bad;
    logic [3:0] exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keys = '0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_col", col, 4'b1110);
    check("reset_value", keypad_value, 0);
    check("reset_keypress", keypress, 0);
    check("reset_pulse", key_pulse, 0);
    check("reset_multi", multi_key, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check("col_step", col, exp_col[i]);
    end

    // Press '5' and hold
    repeat (3) @(negedge clk);
    exp_q.push_back(4'h5);
    press(5);
    wait_drain("press5_latency", 83);
    repeat (40) @(negedge clk);
    check("press5_held", keypress, 1);
    keys = '0;
    wait_release("release5", 83, cyc);
    check("release5_value", keypad_value, 4'h5);

    // Bounce on '9': 2 scans on, 1 off, then held
    repeat (10) @(negedge clk);
    align_scan();
    press(10);
    repeat (32) @(negedge clk);
    keys = '0;
    repeat (16) @(negedge clk);
    exp_q.push_back(4'h9);
    press(10);
    wait_drain("bounce9_latency", 83);
    keys = '0;
    wait_release("release9", 83, cyc);

    // '1' and 'D' together: multi strobe per scan, never accepted
    repeat (10) @(negedge clk);
    align_scan();
    press(0);
    press(15);
    mcount = 0;
    kp_bad = 0;
    for (int i = 0; i < 96; i++) begin
      if (i == 80) keys = '0;
      @(negedge clk);
      if (multi_key) mcount++;
      if (keypress) kp_bad++;
    end
    check("multi_strobes", mcount, 5);
    check("multi_keypress_low", kp_bad, 0);

    // Accept 'A', release, re-press
    exp_q.push_back(4'hA);
    press(3);
    wait_drain("pressA_latency", 83);
    repeat (20) @(negedge clk);
    keys = '0;
    wait_release("releaseA", 83, cyc);
    check("releaseA_not_early", cyc >= 48, 1);
    check("releaseA_value_held", keypad_value, 4'hA);
    repeat (30) @(negedge clk);
    check("releaseA_value_still", keypad_value, 4'hA);
    exp_q.push_back(4'hA);
    press(3);
    wait_drain("repressA_latency", 83);
    keys = '0;
    wait_release("releaseA2", 83, cyc);

    // Random single-key presses at random scan phases
    for (int n = 0; n < 8; n++) begin
      int k;
      k = $urandom_range(0, 15);
      repeat ($urandom_range(1, 16)) @(negedge clk);
      exp_q.push_back(tb_map[k]);
      press(k);
      wait_drain("rand_latency", 83);
      repeat ($urandom_range(0, 31)) @(negedge clk);
      keys = '0;
      wait_release("rand_release", 83, cyc);
      check("rand_value_held", keypad_value, tb_map[k]);
    end

    // Reset while '7' is held
    repeat (5) @(negedge clk);
    exp_q.push_back(4'h7);
    press(8);
    wait_drain("press7_latency", 83);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_col", col, 4'b1110);
    check("midreset_value", keypad_value, 0);
    check("midreset_keypress", keypress, 0);
    check("midreset_pulse", key_pulse, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'h7);
    wait_drain("repress7_latency", 83);
    keys = '0;
    wait_release("release7", 83, cyc);

    repeat (5) @(negedge clk);
    check("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
